nios_system_spi_slave: RTL and testbench

SPI slave (target) peripheral on the Avalon bus, the far end of the existing SPI master link (mode 0, MSB first, 8-bit frames). Oversamples the external SCLK/SS_n/MOSI in the clk domain, shifts out MISO, and exposes rxdata/txdata/status/control/end-of-packet registers with the same two-cycle access timing and bit layout as the master.

---
 rtl/nios_system_spi_slave_pkg.sv | 35 +++
 rtl/nios_system_spi_slave_if.sv | 33 +++
 rtl/nios_system_spi_slave_sync_edge.sv | 51 +++++
 rtl/nios_system_spi_slave.sv | 276 +++++++++++++++++++++++++++
 tb/tb_nios_system_spi_slave.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_spi_slave_pkg.sv
// ============================================================================
// Module : nios_system_spi_pkg
// Brief  : Register map, status/control bit positions and frame states shared
//          by the SPI slave peripheral.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nios_system_spi_pkg;

  localparam logic [2:0] ADDR_RXDATA   = 3'd0;
  localparam logic [2:0] ADDR_TXDATA   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;
  localparam logic [2:0] ADDR_EOPVALUE = 3'd6;

  // Status and interrupt-enable bits share the same positions.
  localparam int BIT_EOP  = 9;
  localparam int BIT_E    = 8;
  localparam int BIT_RRDY = 7;
  localparam int BIT_TRDY = 6;
  localparam int BIT_TMT  = 5;
  localparam int BIT_TOE  = 4;
  localparam int BIT_ROE  = 3;
  localparam int BIT_TUR  = 2;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_LOAD  = 2'd1,
    FS_SHIFT = 2'd2
  } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/nios_system_spi_slave_if.sv
// ============================================================================
// Module : nios_system_spi_slave_if
// Brief  : Avalon register-port bundle of the SPI slave peripheral.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface nios_system_spi_slave_if;

  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;
  logic        endofpacket;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq, dataavailable, readyfordata, endofpacket
  );

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq, dataavailable, readyfordata, endofpacket
  );

endinterface

`default_nettype wire

// File: rtl/nios_system_spi_slave_sync_edge.sv
// ============================================================================
// Module : nios_system_spi_sync_edge
// Brief  : N-stage synchronizer followed by a level register with registered
//          rise/fall pulses aligned to the level output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_system_spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   w_chain;
  logic              w_sync;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  assign w_chain = {sync_q, d_i};
  assign w_sync  = w_chain[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= w_chain[STAGES-1:0];
      level_q <= w_sync;
      rise_q  <= w_sync & ~level_q;
      fall_q  <= ~w_sync & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/nios_system_spi_slave.sv
// ============================================================================
// Module : nios_system_spi_slave
// Brief  : Avalon SPI slave (mode 0, MSB first) with master-compatible
//          register map. Optional macro SPI_SLAVE_UNDERRUN_FLAG_EN adds TUR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_system_spi_slave
  import nios_system_spi_pkg::*;
#(
  parameter int                  DATABITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] DUMMY_BYTE  = DATABITS'(8'h00)
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              SCLK,
  input  wire logic              SS_n,
  input  wire logic              MOSI,
  output logic                   MISO,
  nios_system_spi_slave_if.slave avl
);

  localparam int BCW = $clog2(DATABITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'(FS_IDLE);
  localparam logic [1:0] ST_LOAD  = 2'(FS_LOAD);
  localparam logic [1:0] ST_SHIFT = 2'(FS_SHIFT);

  localparam logic [15:0] CTRL_BASE = (16'd1 << BIT_EOP) | (16'd1 << BIT_E)
                                    | (16'd1 << BIT_RRDY) | (16'd1 << BIT_TRDY)
                                    | (16'd1 << BIT_TOE) | (16'd1 << BIT_ROE);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
  localparam logic [15:0] CTRL_MASK = CTRL_BASE | (16'd1 << BIT_TUR);
`else
  localparam logic [15:0] CTRL_MASK = CTRL_BASE;
`endif

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic [SYNC_STAGES:0] mosi_sync_q;
  logic w_mosi;

  logic [1:0]          state_q, state_d;
  logic [DATABITS-1:0] sr_q, sr_d;
  logic [BCW-1:0]      bitcnt_q, bitcnt_d;
  logic                mosi_bit_q, mosi_bit_d;
  logic [DATABITS-1:0] rx_q, rx_d;
  logic [DATABITS-1:0] tx_q, tx_d;
  logic                primed_q, primed_d;
  logic                rrdy_q, rrdy_d;
  logic                roe_q, roe_d;
  logic                toe_q, toe_d;
  logic                eop_q, eop_d;
  logic                tur_q, tur_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [15:0]         eopval_q, eopval_d;
  logic [15:0]         dout_q, dout_d;
  logic                irq_q, irq_d;
  logic                rd_stb_q, rd_stb_d;
  logic                wr_stb_q, wr_stb_d;

  logic        w_load, w_byte_done;
  logic        w_rd_rx, w_wr_tx, w_wr_status, w_wr_ctrl, w_wr_eop;
  logic [15:0] w_status, w_rdmux;
  logic        w_unused;

  nios_system_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (reset_n),
    .d_i     (SCLK),
    .level_o (w_sclk_level),
    .rise_o  (w_sclk_rise),
    .fall_o  (w_sclk_fall)
  );

  nios_system_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .rst_n   (reset_n),
    .d_i     (SS_n),
    .level_o (w_ss_level),
    .rise_o  (w_ss_rise),
    .fall_o  (w_ss_fall)
  );

  assign w_unused = &{1'b0, w_sclk_level, w_ss_rise};

  // One extra stage keeps MOSI aligned with the SCLK edge pulses.
  assign w_mosi = mosi_sync_q[SYNC_STAGES];

  assign rd_stb_d    = avl.spi_select & ~avl.read_n  & ~rd_stb_q;
  assign wr_stb_d    = avl.spi_select & ~avl.write_n & ~wr_stb_q;
  assign w_rd_rx     = rd_stb_q & (avl.mem_addr == ADDR_RXDATA);
  assign w_wr_tx     = wr_stb_q & (avl.mem_addr == ADDR_TXDATA);
  assign w_wr_status = wr_stb_q & (avl.mem_addr == ADDR_STATUS);
  assign w_wr_ctrl   = wr_stb_q & (avl.mem_addr == ADDR_CONTROL);
  assign w_wr_eop    = wr_stb_q & (avl.mem_addr == ADDR_EOPVALUE);

  always_comb begin
    w_status           = 16'h0000;
    w_status[BIT_EOP]  = eop_q;
    w_status[BIT_E]    = toe_q | roe_q;
    w_status[BIT_RRDY] = rrdy_q;
    w_status[BIT_TRDY] = ~primed_q;
    w_status[BIT_TMT]  = ~primed_q & (state_q == ST_IDLE);
    w_status[BIT_TOE]  = toe_q;
    w_status[BIT_ROE]  = roe_q;
    w_status[BIT_TUR]  = tur_q;
  end

  always_comb begin
    case (avl.mem_addr)
      ADDR_RXDATA:   w_rdmux = 16'(rx_q);
      ADDR_STATUS:   w_rdmux = w_status;
      ADDR_CONTROL:  w_rdmux = ctrl_q;
      ADDR_EOPVALUE: w_rdmux = eopval_q;
      default:       w_rdmux = 16'h0000;
    endcase
  end

  // Frame sequencer: RX bit is captured on SCLK rise and folded into the
  // shift register on the following fall so the TX LSB is not overwritten.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    mosi_bit_d  = mosi_bit_q;
    rx_d        = rx_q;
    w_load      = 1'b0;
    w_byte_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_ss_level) begin
          state_d = ST_IDLE;
        end else begin
          w_load   = 1'b1;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ss_level) begin
          state_d = ST_IDLE;
        end else if (w_sclk_rise) begin
          mosi_bit_d = w_mosi;
          bitcnt_d   = bitcnt_q + 1'b1;
          if (bitcnt_q == BCW'(DATABITS - 1)) begin
            w_byte_done = 1'b1;
            rx_d        = {sr_q[DATABITS-2:0], w_mosi};
          end
        end else if (w_sclk_fall) begin
          if (bitcnt_q == BCW'(DATABITS)) begin
            w_load   = 1'b1;
            bitcnt_d = '0;
          end else begin
            sr_d = {sr_q[DATABITS-2:0], mosi_bit_q};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_load) sr_d = primed_q ? tx_q : DUMMY_BYTE;
  end

  always_comb begin
    primed_d = primed_q;
    tx_d     = tx_q;
    rrdy_d   = rrdy_q;
    roe_d    = roe_q;
    toe_d    = toe_q;
    eop_d    = eop_q;
    tur_d    = tur_q;
    ctrl_d   = ctrl_q;
    eopval_d = eopval_q;

    if (w_wr_status) begin
      rrdy_d = 1'b0;
      roe_d  = 1'b0;
      toe_d  = 1'b0;
      eop_d  = 1'b0;
      tur_d  = 1'b0;
    end

    if (w_load && primed_q) primed_d = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    if (w_load && !primed_q) tur_d = 1'b1;
`else
    tur_d = 1'b0;
`endif

    // Writes are judged against the pre-load primed flag, so a write racing
    // a load never overwrites the byte being loaded.
    if (w_wr_tx) begin
      if (primed_q) begin
        toe_d = 1'b1;
      end else begin
        primed_d = 1'b1;
        tx_d     = avl.data_from_cpu[DATABITS-1:0];
      end
    end

    if (w_rd_rx && !w_byte_done) rrdy_d = 1'b0;
    if (w_byte_done) begin
      rrdy_d = 1'b1;
      if (rrdy_q && !w_rd_rx) roe_d = 1'b1;
    end

    if ((w_rd_rx && (rx_q == eopval_q[DATABITS-1:0])) ||
        (w_wr_tx && (avl.data_from_cpu[DATABITS-1:0] == eopval_q[DATABITS-1:0])))
      eop_d = 1'b1;

    if (w_wr_ctrl) ctrl_d   = avl.data_from_cpu & CTRL_MASK;
    if (w_wr_eop)  eopval_d = avl.data_from_cpu;
  end

  assign dout_d = rd_stb_q ? w_rdmux : dout_q;
  assign irq_d  = |(w_status & ctrl_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      mosi_bit_q  <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      primed_q    <= 1'b0;
      rrdy_q      <= 1'b0;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      eop_q       <= 1'b0;
      tur_q       <= 1'b0;
      ctrl_q      <= 16'h0000;
      eopval_q    <= 16'h0000;
      dout_q      <= 16'h0000;
      irq_q       <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], MOSI};
      state_q     <= state_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      mosi_bit_q  <= mosi_bit_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      primed_q    <= primed_d;
      rrdy_q      <= rrdy_d;
      roe_q       <= roe_d;
      toe_q       <= toe_d;
      eop_q       <= eop_d;
      tur_q       <= tur_d;
      ctrl_q      <= ctrl_d;
      eopval_q    <= eopval_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
    end
  end

  assign MISO              = ~w_ss_level & sr_q[DATABITS-1];
  assign avl.data_to_cpu   = dout_q;
  assign avl.irq           = irq_q;
  assign avl.dataavailable = rrdy_q;
  assign avl.readyfordata  = ~primed_q;
  assign avl.endofpacket   = eop_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_system_spi_slave.sv
// ============================================================================
// Module : tb_nios_system_spi_slave
// Brief  : Directed self-checking bench for the Avalon SPI slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nios_system_spi_slave;
  import nios_system_spi_pkg::*;

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
  localparam logic [15:0] C_TUR = 16'h0004;
`else
  localparam logic [15:0] C_TUR = 16'h0000;
`endif
  localparam int C_HALF = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic SCLK;
  logic SS_n;
  logic MOSI;
  logic MISO;

  nios_system_spi_slave_if bus ();

  nios_system_spi_slave dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SCLK    (SCLK),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .avl     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic avl_read(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.spi_select = 1'b1;
    bus.mem_addr   = addr;
    bus.read_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.spi_select = 1'b0;
    bus.read_n     = 1'b1;
    data = bus.data_to_cpu;
  endtask

  task automatic avl_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.spi_select    = 1'b1;
    bus.mem_addr      = addr;
    bus.write_n       = 1'b0;
    bus.data_from_cpu = data;
    @(negedge clk);
    @(negedge clk);
    bus.spi_select = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: MOSI set before each rise, MISO sampled just before it.
  task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [15:0] rx_miso);
    rx_miso = 16'h0000;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = tx[nbits-1];
    wait_clk(C_HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      rx_miso = {rx_miso[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(C_HALF);
      SCLK = 1'b0;
      if (i > 0) MOSI = tx[i-1];
      wait_clk(C_HALF);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clk(C_HALF);
  endtask

  logic [15:0] rd;
  logic [15:0] mi;

  initial begin
    reset_n           = 1'b0;
    SCLK              = 1'b0;
    SS_n              = 1'b1;
    MOSI              = 1'b0;
    bus.spi_select    = 1'b0;
    bus.mem_addr      = 3'd0;
    bus.read_n        = 1'b1;
    bus.write_n       = 1'b1;
    bus.data_from_cpu = 16'h0000;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(2);

    // Reset state
    check_eq("rst_dout", bus.data_to_cpu, 16'h0000);
    check_eq("rst_miso", {15'd0, MISO}, 16'h0000);
    check_eq("rst_irq", {15'd0, bus.irq}, 16'h0000);
    check_eq("rst_trdy", {15'd0, bus.readyfordata}, 16'h0001);
    avl_read(ADDR_STATUS, rd);
    check_eq("rst_status", rd, 16'h0060);

    // Primed byte out, 0x3C in
    avl_write(ADDR_TXDATA, 16'h00A5);
    avl_read(ADDR_STATUS, rd);
    check_eq("t2_status_primed", rd, 16'h0000);
    spi_xfer(16'h003C, 8, mi);
    check_eq("t2_miso", mi, 16'h00A5);
    check_eq("t2_rrdy_pin", {15'd0, bus.dataavailable}, 16'h0001);
    avl_read(ADDR_STATUS, rd);
    check_eq("t2_status_rx", rd, 16'h00E0 | C_TUR);
    avl_read(ADDR_RXDATA, rd);
    check_eq("t2_rxdata", rd, 16'h003C);
    avl_read(ADDR_STATUS, rd);
    check_eq("t2_status_after_rd", rd, 16'h0060 | C_TUR);

    // Overrun across a two-byte frame, E interrupt
    avl_write(ADDR_STATUS, 16'h0000);
    spi_xfer(16'h1122, 16, mi);
    check_eq("t3_miso_dummy", mi, 16'h0000);
    avl_read(ADDR_STATUS, rd);
    check_eq("t3_status_roe", rd, 16'h01E8 | C_TUR);
    check_eq("t3_irq_off", {15'd0, bus.irq}, 16'h0000);
    avl_write(ADDR_CONTROL, 16'h0100);
    wait_clk(2);
    check_eq("t3_irq_on", {15'd0, bus.irq}, 16'h0001);
    avl_read(ADDR_CONTROL, rd);
    check_eq("t3_control", rd, 16'h0100);
    avl_write(ADDR_STATUS, 16'h0000);
    wait_clk(2);
    check_eq("t3_irq_clr", {15'd0, bus.irq}, 16'h0000);
    avl_read(ADDR_RXDATA, rd);
    check_eq("t3_rxdata", rd, 16'h0022);
    avl_write(ADDR_CONTROL, 16'h0000);

    // Underrun: nothing primed
    avl_write(ADDR_STATUS, 16'h0000);
    spi_xfer(16'h00FF, 8, mi);
    check_eq("t4_miso_dummy", mi, 16'h0000);
    avl_read(ADDR_STATUS, rd);
    check_eq("t4_status", rd, 16'h00E0 | C_TUR);
    avl_read(ADDR_RXDATA, rd);
    check_eq("t4_rxdata", rd, 16'h00FF);

    // Transmit overrun; rx byte matches eopvalue 0
    avl_write(ADDR_STATUS, 16'h0000);
    avl_write(ADDR_TXDATA, 16'h0081);
    avl_write(ADDR_TXDATA, 16'h0042);
    avl_read(ADDR_STATUS, rd);
    check_eq("t5_status_toe", rd, 16'h0110);
    spi_xfer(16'h0000, 8, mi);
    check_eq("t5_miso_first", mi, 16'h0081);
    avl_read(ADDR_RXDATA, rd);
    check_eq("t5_rxdata", rd, 16'h0000);
    avl_read(ADDR_STATUS, rd);
    check_eq("t5_status_eop", rd, 16'h0370 | C_TUR);
    check_eq("t5_eop_pin", {15'd0, bus.endofpacket}, 16'h0001);

    // Aborted partial frame, then full byte
    avl_write(ADDR_STATUS, 16'h0000);
    spi_xfer(16'h000A, 4, mi);
    avl_read(ADDR_STATUS, rd);
    check_eq("t6_status_partial", rd, 16'h0060 | C_TUR);
    spi_xfer(16'h005A, 8, mi);
    avl_read(ADDR_STATUS, rd);
    check_eq("t6_status_full", rd, 16'h00E0 | C_TUR);
    avl_read(ADDR_RXDATA, rd);
    check_eq("t6_rxdata", rd, 16'h005A);

    // eopvalue register, tx EOP, unmapped addresses
    avl_write(ADDR_EOPVALUE, 16'h1233);
    avl_read(ADDR_EOPVALUE, rd);
    check_eq("t7_eopvalue", rd, 16'h1233);
    avl_write(ADDR_TXDATA, 16'h0033);
    avl_read(ADDR_STATUS, rd);
    check_eq("t7_status_eop_tx", rd, 16'h0200 | C_TUR);
    avl_read(3'd5, rd);
    check_eq("t7_unmapped_rd", rd, 16'h0000);
    avl_write(3'd7, 16'hFFFF);
    avl_read(ADDR_CONTROL, rd);
    check_eq("t7_unmapped_wr", rd, 16'h0000);

    // Reset asserted mid-frame
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b1;
    wait_clk(C_HALF);
    SCLK = 1'b1;
    wait_clk(C_HALF);
    reset_n = 1'b0;
    wait_clk(2);
    SCLK = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
    reset_n = 1'b1;
    wait_clk(C_HALF);
    check_eq("t8_miso", {15'd0, MISO}, 16'h0000);
    avl_read(ADDR_STATUS, rd);
    check_eq("t8_status", rd, 16'h0060);
    avl_read(ADDR_EOPVALUE, rd);
    check_eq("t8_eopvalue", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
